// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and hex-to-segment table for the scan driver
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF    = 7'h7F;
    localparam int   NUM_DIGITS = 4;

    // Patterns are {g,f,e,d,c,b,a}, active-low.
    function automatic seg_t hex_to_seg(input logic [3:0] n);
        seg_t s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low 7-segment pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed hex display driver with frame-locked sampling
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100_000,
    parameter int GUARD_CYC       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        mode,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int             CNT_W    = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [1:0]     DIG_LAST = 2'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      hold_q, hold_d;
    logic             mode_q, mode_d;
    logic             blz_q, blz_d;
    logic [3:0]       an_q, an_d;
    seg_t             seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             wrap;
    logic             sample;
    logic             in_guard;
    logic             blank;
    logic [3:0]       nibble;
    seg_t             hex_seg;

    assign nibble = hold_q[{digit_q, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        wrap     = (cnt_q == CNT_LAST);
        sample   = wrap && (digit_q == DIG_LAST);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        digit_d  = wrap ? digit_q + 2'd1 : digit_q;
        // Inputs are captured only at the frame boundary so a frame never tears.
        hold_d   = sample ? value    : hold_q;
        mode_d   = sample ? mode     : mode_q;
        blz_d    = sample ? blank_lz : blz_q;
        in_guard = int'(cnt_q) < GUARD_CYC;

        case (digit_q)
            2'd1:    blank = blz_q && (hold_q[15:4]  == 12'd0);
            2'd2:    blank = blz_q && (hold_q[15:8]  == 8'd0);
            2'd3:    blank = blz_q && (hold_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase

        if (in_guard) begin
            an_d  = 4'b1111;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = blank ? SEG_OFF : hex_seg;
            dp_d  = !((digit_q == DIG_LAST) && mode_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            digit_q <= 2'd0;
            hold_q  <= 16'h0000;
            mode_q  <= 1'b0;
            blz_q   <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            blz_q   <= blz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
